neural_acc_axil_slave: RTL and testbench

AXI4-Lite responder for the neural accelerator's S00_AXI control/configuration port. It sits behind the block-design AXI interconnect and decodes single-beat reads and writes into a bank of 32-bit registers. Register contents and per-register write pulses are presented to the accelerator core. A master issuing four sequential writes to 0x0, 0x4, 0x8 and 0xC must read back identical data from those addresses.

---
 rtl/neural_acc_axil_pkg.sv | 15 +
 rtl/neural_acc_reg_bank.sv | 39 +++
 rtl/neural_acc_axil_slave.sv | 152 +++++++++++++++
 tb/tb_neural_acc_axil_slave.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neural_acc_axil_pkg.sv
// neural_acc_axil_pkg: response codes, FSM state types and address decode shared by the AXI4-Lite register slave.
package neural_acc_axil_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    // Word index of a zero-extended byte address; the two byte-lane bits are dropped.
    function automatic int unsigned idx_of(input logic [31:0] addr);
        return addr >> 2;
    endfunction

endpackage

// File: rtl/neural_acc_reg_bank.sv
// neural_acc_reg_bank: NUM_REGS x 32-bit storage with byte-enable write, combinational read and one-cycle write pulses.
module neural_acc_reg_bank #(
    parameter int NUM_REGS = 4,
    parameter int IW       = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [IW-1:0]          wr_idx,
    input  logic [31:0]            wr_data,
    input  logic [3:0]             wr_strb,
    input  logic [IW-1:0]          rd_idx,
    output logic [31:0]            rd_data,
    output logic [NUM_REGS*32-1:0] reg_q,
    output logic [NUM_REGS-1:0]    reg_wr_pulse
);

    logic [31:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
            reg_wr_pulse <= '0;
        end else begin
            reg_wr_pulse <= '0;
            if (wr_en) begin
                for (int b = 0; b < 4; b++)
                    if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                reg_wr_pulse[wr_idx] <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_data = regs[rd_idx];
        for (int k = 0; k < NUM_REGS; k++) reg_q[32*k +: 32] = regs[k];
    end

endmodule

// File: rtl/neural_acc_axil_slave.sv
// neural_acc_axil_slave: AXI4-Lite control-port slave with independent write/read handshake FSMs over a register bank.
// Define NEURAL_ACC_AXIL_SLVERR_EN to answer out-of-range indices with SLVERR instead of wrapping them modulo NUM_REGS.
module neural_acc_axil_slave
    import neural_acc_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]          reg_q,
    output logic [NUM_REGS-1:0]             reg_wr_pulse
);

    localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;

    wr_state_t                     wr_state;
    rd_state_t                     rd_state;
    logic                          aw_held, w_held, aw_hs, w_hs, commit, wr_ok, rd_ok;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q, wr_addr;
    logic [31:0]                   w_data_q, wr_data, rd_data;
    logic [3:0]                    w_strb_q, wr_strb;
    int unsigned                   wr_i, rd_i;
    logic [IW-1:0]                 wr_idx, rd_idx;
    logic                          unused_prot;

    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // Commit happens on the edge that completes the AW/W pair, mixing latched and live halves.
    always_comb begin
        aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
        w_hs    = S_AXI_WVALID && S_AXI_WREADY;
        commit  = wr_state == WR_IDLE && (aw_hs || aw_held) && (w_hs || w_held);
        wr_addr = aw_held ? aw_addr_q : S_AXI_AWADDR;
        wr_data = w_held ? w_data_q : S_AXI_WDATA;
        wr_strb = w_held ? w_strb_q : S_AXI_WSTRB;
        wr_i    = idx_of(32'(wr_addr));
        rd_i    = idx_of(32'(S_AXI_ARADDR));
`ifdef NEURAL_ACC_AXIL_SLVERR_EN
        wr_ok   = wr_i < NUM_REGS;
        rd_ok   = rd_i < NUM_REGS;
`else
        wr_ok   = 1'b1;
        rd_ok   = 1'b1;
        wr_i    = wr_i % NUM_REGS;
        rd_i    = rd_i % NUM_REGS;
`endif
        wr_idx  = IW'(wr_i);
        rd_idx  = IW'(rd_i);
    end

    neural_acc_reg_bank #(.NUM_REGS(NUM_REGS), .IW(IW)) u_bank (
        .clk          (S_AXI_ACLK),
        .rst          (S_AXI_ARESET),
        .wr_en        (commit && wr_ok),
        .wr_idx       (wr_idx),
        .wr_data      (wr_data),
        .wr_strb      (wr_strb),
        .rd_idx       (rd_idx),
        .rd_data      (rd_data),
        .reg_q        (reg_q),
        .reg_wr_pulse (reg_wr_pulse)
    );

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wr_state      <= WR_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= AXI_RESP_OKAY;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
        end else if (wr_state == WR_IDLE) begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= S_AXI_AWADDR;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (commit) begin
                wr_state      <= WR_RESP;
                S_AXI_AWREADY <= 1'b0;
                S_AXI_WREADY  <= 1'b0;
                S_AXI_BVALID  <= 1'b1;
                S_AXI_BRESP   <= wr_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end else begin
                S_AXI_AWREADY <= !(aw_held || aw_hs);
                S_AXI_WREADY  <= !(w_held || w_hs);
            end
        end else if (S_AXI_BREADY) begin
            wr_state      <= WR_IDLE;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
        end
    end

    // Read data is captured from the pre-edge register values, so a same-edge write is not visible.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rd_state      <= RD_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= AXI_RESP_OKAY;
        end else if (rd_state == RD_IDLE) begin
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                rd_state      <= RD_DATA;
                S_AXI_ARREADY <= 1'b0;
                S_AXI_RVALID  <= 1'b1;
                S_AXI_RDATA   <= rd_ok ? rd_data : '0;
                S_AXI_RRESP   <= rd_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end else begin
                S_AXI_ARREADY <= 1'b1;
            end
        end else if (S_AXI_RREADY) begin
            rd_state      <= RD_IDLE;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
        end
    end

endmodule

// File: tb/tb_neural_acc_axil_slave.sv
// tb_neural_acc_axil_slave: randomized and directed AXI4-Lite traffic checked against a word-array reference model.
module tb_neural_acc_axil_slave;

    localparam int AW = 6;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [2:0]    awprot = '0, arprot = '0;
    logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [1:0]    bresp, rresp;
    logic [31:0]   rdata;
    logic [N*32-1:0] reg_q;
    logic [N-1:0]  pulse;

    int checks = 0, failures = 0;
    logic [31:0] model [N];

    always #5 clk = ~clk;

    neural_acc_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW), .NUM_REGS(N)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_q(reg_q), .reg_wr_pulse(pulse)
    );

    function automatic logic [N*32-1:0] model_q();
        logic [N*32-1:0] q;
        for (int k = 0; k < N; k++) q[32*k +: 32] = model[k];
        return q;
    endfunction

    task automatic model_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               output logic [1:0] resp, output logic [N-1:0] p);
        int idx = int'(addr) / 4;
        p = '0;
        resp = 2'b00;
`ifdef NEURAL_ACC_AXIL_SLVERR_EN
        if (idx >= N) begin
            resp = 2'b10;
            return;
        end
`else
        idx = idx % N;
`endif
        for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        p[idx] = 1'b1;
    endtask

    task automatic model_read(input logic [AW-1:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int idx = int'(addr) / 4;
        data = '0;
        resp = 2'b00;
`ifdef NEURAL_ACC_AXIL_SLVERR_EN
        if (idx >= N) begin
            resp = 2'b10;
            return;
        end
`else
        idx = idx % N;
`endif
        data = model[idx];
    endtask

    // ok drops on any protocol slip: early/extra response or pulse, unstable B under backpressure, bound expiry.
    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [1:0] resp, output logic [N-1:0] p, output logic ok);
        logic aw_done = 1'b0, w_done = 1'b0, aw_f, w_f;
        int cyc = 0;
        ok = 1'b1;
        resp = '0;
        p = '0;
        while (!(aw_done && w_done) && cyc < 40) begin
            @(negedge clk);
            if (bvalid || pulse != '0) ok = 1'b0;
            awvalid = !aw_done && cyc >= aw_dly;
            awaddr  = addr;
            wvalid  = !w_done && cyc >= w_dly;
            wdata   = data;
            wstrb   = strb;
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            @(posedge clk);
            aw_done |= aw_f;
            w_done  |= w_f;
            cyc++;
        end
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            ok = 1'b0;
            return;
        end
        if (!bvalid) ok = 1'b0;
        resp = bresp;
        p = pulse;
        repeat (b_dly) begin
            @(negedge clk);
            if (!bvalid || bresp !== resp || awready || wready || pulse != '0) ok = 1'b0;
        end
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
        if (bvalid || pulse != '0) ok = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input int r_dly,
                            output logic [31:0] data, output logic [1:0] resp, output logic ok);
        int cyc = 0;
        ok = 1'b1;
        data = '0;
        resp = '0;
        @(negedge clk);
        arvalid = 1'b1;
        araddr  = addr;
        while (!arready && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!arready) begin
            arvalid = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        if (!rvalid) ok = 1'b0;
        data = rdata;
        resp = rresp;
        repeat (r_dly) begin
            @(negedge clk);
            if (!rvalid || rdata !== data || rresp !== resp || arready) ok = 1'b0;
        end
        rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rready = 1'b0;
        if (rvalid) ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=00000", {awready, wready, bvalid, arready, rvalid}); end
        checks++; if ({bresp, rresp} !== 4'b0) begin failures++; $display("FAIL reset_resp got=%b exp=0000", {bresp, rresp}); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        checks++; if (reg_q !== '0) begin failures++; $display("FAIL reset_regs got=%h exp=0", reg_q); end
        checks++; if (pulse !== '0) begin failures++; $display("FAIL reset_pulse got=%b exp=0", pulse); end
        rst = 1'b0;
        for (int k = 0; k < N; k++) model[k] = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sequential();
        logic [1:0] r, er;
        logic [N-1:0] p, ep;
        logic [31:0] d, ed;
        logic ok;
        for (int i = 0; i < 4; i++) begin
            axi_write(AW'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0, r, p, ok);
            model_write(AW'(i * 4), 32'(i + 1), 4'hF, er, ep);
            checks++; if ({r, p} !== {er, ep} || !ok) begin failures++; $display("FAIL seq_write[%0d] got resp=%b pulse=%b ok=%b exp resp=%b pulse=%b ok=1", i, r, p, ok, er, ep); end
        end
        checks++; if (reg_q !== {32'd4, 32'd3, 32'd2, 32'd1}) begin failures++; $display("FAIL seq_reg_q got=%h exp=4_3_2_1", reg_q); end
        for (int i = 0; i < 4; i++) begin
            axi_read(AW'(i * 4), 0, d, r, ok);
            model_read(AW'(i * 4), ed, er);
            checks++; if ({d, r} !== {ed, er} || !ok) begin failures++; $display("FAIL seq_read[%0d] got data=%h resp=%b ok=%b exp data=%h resp=%b", i, d, r, ok, ed, er); end
        end
    endtask

    task automatic test_split();
        logic [1:0] r, er;
        logic [N-1:0] p, ep;
        logic ok;
        for (int s = 0; s < 2; s++) begin
            axi_write(6'h08, 32'hDEADBEEF, 4'hF, s == 0 ? 0 : 3, s == 0 ? 3 : 0, 0, r, p, ok);
            model_write(6'h08, 32'hDEADBEEF, 4'hF, er, ep);
            checks++; if ({r, p} !== {2'b00, 4'b0100} || !ok) begin failures++; $display("FAIL split[%0d] got resp=%b pulse=%b ok=%b exp resp=00 pulse=0100 ok=1", s, r, p, ok); end
            checks++; if (reg_q !== model_q()) begin failures++; $display("FAIL split_regs[%0d] got=%h exp=%h", s, reg_q, model_q()); end
        end
    endtask

    task automatic test_strobe();
        logic [1:0] r, er;
        logic [N-1:0] p, ep;
        logic [31:0] d;
        logic ok;
        axi_write(6'h04, 32'h11223344, 4'hF, 0, 0, 0, r, p, ok);
        model_write(6'h04, 32'h11223344, 4'hF, er, ep);
        axi_write(6'h04, 32'hAABBCCDD, 4'b0101, 1, 0, 0, r, p, ok);
        model_write(6'h04, 32'hAABBCCDD, 4'b0101, er, ep);
        axi_read(6'h04, 0, d, r, ok);
        checks++; if (d !== 32'h11BB33DD || r !== 2'b00 || !ok) begin failures++; $display("FAIL strobe_merge got data=%h resp=%b ok=%b exp data=11bb33dd resp=00", d, r, ok); end
        axi_write(6'h04, 32'hFFFFFFFF, 4'b0000, 0, 0, 0, r, p, ok);
        model_write(6'h04, 32'hFFFFFFFF, 4'b0000, er, ep);
        checks++; if ({r, p} !== {2'b00, 4'b0010} || !ok) begin failures++; $display("FAIL strobe_zero got resp=%b pulse=%b ok=%b exp resp=00 pulse=0010", r, p, ok); end
        checks++; if (reg_q[63:32] !== 32'h11BB33DD) begin failures++; $display("FAIL strobe_zero_keep got=%h exp=11bb33dd", reg_q[63:32]); end
    endtask

    task automatic test_backpressure();
        logic [1:0] r, er;
        logic [N-1:0] p, ep;
        logic [31:0] d, ed, v;
        logic ok;
        v = $urandom;
        axi_write(6'h0C, v, 4'hF, 0, 0, 5, r, p, ok);
        model_write(6'h0C, v, 4'hF, er, ep);
        checks++; if ({r, p} !== {er, ep} || !ok) begin failures++; $display("FAIL bp_write got resp=%b pulse=%b ok=%b exp resp=%b pulse=%b ok=1", r, p, ok, er, ep); end
        axi_read(6'h0C, 5, d, r, ok);
        model_read(6'h0C, ed, er);
        checks++; if ({d, r} !== {ed, er} || !ok) begin failures++; $display("FAIL bp_read got data=%h resp=%b ok=%b exp data=%h resp=%b ok=1", d, r, ok, ed, er); end
    endtask

    task automatic test_same_edge();
        logic [1:0] r, er;
        logic [N-1:0] p, ep;
        logic [31:0] d;
        logic ok;
        axi_write(6'h00, 32'h1, 4'hF, 0, 0, 0, r, p, ok);
        model_write(6'h00, 32'h1, 4'hF, er, ep);
        @(negedge clk);
        checks++; if (!(awready && wready && arready)) begin failures++; $display("FAIL same_edge_ready got=%b exp=111", {awready, wready, arready}); end
        awaddr = 6'h00; wdata = 32'h55; wstrb = 4'hF; araddr = 6'h00;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        checks++; if ({rvalid, rdata, rresp} !== {1'b1, 32'h1, 2'b00}) begin failures++; $display("FAIL same_edge_read got valid=%b data=%h resp=%b exp valid=1 data=1 resp=00", rvalid, rdata, rresp); end
        checks++; if ({bvalid, bresp, pulse} !== {1'b1, 2'b00, 4'b0001}) begin failures++; $display("FAIL same_edge_write got valid=%b resp=%b pulse=%b exp 1 00 0001", bvalid, bresp, pulse); end
        bready = 1'b1; rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        model_write(6'h00, 32'h55, 4'hF, er, ep);
        axi_read(6'h00, 0, d, r, ok);
        checks++; if (d !== 32'h55 || !ok) begin failures++; $display("FAIL same_edge_after got data=%h ok=%b exp data=55", d, ok); end
    endtask

    task automatic test_out_of_range();
        logic [1:0] r, er;
        logic [N-1:0] p, ep;
        logic [31:0] d, ed;
        logic ok;
        axi_write(6'h20, 32'h9, 4'hF, 0, 0, 0, r, p, ok);
        model_write(6'h20, 32'h9, 4'hF, er, ep);
        checks++; if ({r, p} !== {er, ep} || !ok) begin failures++; $display("FAIL oor_write got resp=%b pulse=%b ok=%b exp resp=%b pulse=%b", r, p, ok, er, ep); end
        checks++; if (reg_q !== model_q()) begin failures++; $display("FAIL oor_regs got=%h exp=%h", reg_q, model_q()); end
        axi_read(6'h20, 0, d, r, ok);
        model_read(6'h20, ed, er);
        checks++; if ({d, r} !== {ed, er} || !ok) begin failures++; $display("FAIL oor_read got data=%h resp=%b ok=%b exp data=%h resp=%b", d, r, ok, ed, er); end
    endtask

    task automatic test_random();
        logic [1:0] r, er;
        logic [N-1:0] p, ep;
        logic [31:0] d, ed, v;
        logic [3:0] s;
        logic [AW-1:0] a;
        logic ok;
        for (int i = 0; i < 40; i++) begin
            a = AW'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                v = $urandom;
                s = 4'($urandom);
                axi_write(a, v, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), r, p, ok);
                model_write(a, v, s, er, ep);
                checks++; if ({r, p} !== {er, ep} || !ok) begin failures++; $display("FAIL rand_write[%0d] addr=%h got resp=%b pulse=%b ok=%b exp resp=%b pulse=%b", i, a, r, p, ok, er, ep); end
            end else begin
                axi_read(a, int'($urandom_range(0, 2)), d, r, ok);
                model_read(a, ed, er);
                checks++; if ({d, r} !== {ed, er} || !ok) begin failures++; $display("FAIL rand_read[%0d] addr=%h got data=%h resp=%b ok=%b exp data=%h resp=%b", i, a, d, r, ok, ed, er); end
            end
        end
        checks++; if (reg_q !== model_q()) begin failures++; $display("FAIL rand_regs got=%h exp=%h", reg_q, model_q()); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] r;
        logic [31:0] d;
        logic ok;
        @(negedge clk);
        awaddr = 6'h0C; wdata = $urandom | 32'h1; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        checks++; if (bvalid !== 1'b1) begin failures++; $display("FAIL rstmid_pre_bvalid got=%b exp=1", bvalid); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N; k++) model[k] = '0;
        checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL rstmid_bvalid got=%b exp=0", bvalid); end
        checks++; if (reg_q !== '0) begin failures++; $display("FAIL rstmid_regs got=%h exp=0", reg_q); end
        axi_read(6'h0C, 0, d, r, ok);
        checks++; if (d !== 32'h0 || r !== 2'b00 || !ok) begin failures++; $display("FAIL rstmid_read got data=%h resp=%b ok=%b exp data=0 resp=00", d, r, ok); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_split();
        test_strobe();
        test_backpressure();
        test_same_edge();
        test_out_of_range();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
